// File: rtl/normalization_shifter.sv
// ============================================================================
// normalization_shifter: two-stage leading-bit count + left-normalizing shift.
// Revision: 1.0
// ============================================================================
`default_nettype none

module leading_bits_counter #(
  parameter int DATA_WIDTH   = 64,
  parameter bit BIT_TO_COUNT = 1'b0,
  parameter int SHIFT_WIDTH  = $clog2(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0]  data,
  output logic [SHIFT_WIDTH-1:0] count
);

  logic found;

  // A run covering the whole word saturates at DATA_WIDTH-1 so it fits SHIFT_WIDTH.
  always_comb begin
    count = SHIFT_WIDTH'(DATA_WIDTH - 1);
    found = 1'b0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      if (!found && (data[i] != BIT_TO_COUNT)) begin
        count = SHIFT_WIDTH'(DATA_WIDTH - 1 - i);
        found = 1'b1;
      end
    end
  end

endmodule

module normalization_shifter #(
  parameter int DATA_WIDTH  = 64,
  parameter int SHIFT_WIDTH = $clog2(DATA_WIDTH),
  parameter int TAG_WIDTH   = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   in_signed,
  input  logic [TAG_WIDTH-1:0]   in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [SHIFT_WIDTH-1:0] out_shift,
  output logic                   out_zero,
  output logic [TAG_WIDTH-1:0]   out_tag
);

  logic [SHIFT_WIDTH-1:0] lz_count;
  logic [SHIFT_WIDTH-1:0] lo_count;
  logic [SHIFT_WIDTH-1:0] count_sel;

  leading_bits_counter #(
    .DATA_WIDTH  (DATA_WIDTH),
    .BIT_TO_COUNT(1'b0),
    .SHIFT_WIDTH (SHIFT_WIDTH)
  ) u_lead_zeros (
    .data (in_data),
    .count(lz_count)
  );

  leading_bits_counter #(
    .DATA_WIDTH  (DATA_WIDTH),
    .BIT_TO_COUNT(1'b1),
    .SHIFT_WIDTH (SHIFT_WIDTH)
  ) u_lead_ones (
    .data (in_data),
    .count(lo_count)
  );

  assign count_sel = (in_signed && in_data[DATA_WIDTH-1]) ? lo_count : lz_count;

  logic                   s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0]  s1_data_q, s1_data_d;
  logic                   s1_signed_q, s1_signed_d;
  logic [TAG_WIDTH-1:0]   s1_tag_q, s1_tag_d;
  logic [SHIFT_WIDTH-1:0] s1_count_q, s1_count_d;
  logic                   s1_zero_q, s1_zero_d;

  logic                   out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
  logic [SHIFT_WIDTH-1:0] out_shift_q, out_shift_d;
  logic                   out_zero_q, out_zero_d;
  logic [TAG_WIDTH-1:0]   out_tag_q, out_tag_d;

  logic                   s1_advance;
  logic [SHIFT_WIDTH-1:0] shift_amt;

  assign s1_advance = !out_valid_q || out_ready;
  assign in_ready   = !s1_valid_q || s1_advance;

  // Signed mode keeps one copy of the sign bit, so it shifts one less than the run.
  always_comb begin
    if (s1_zero_q) begin
      shift_amt = '0;
    end else if (s1_signed_q) begin
      shift_amt = (s1_count_q == '0) ? '0 : s1_count_q - SHIFT_WIDTH'(1);
    end else begin
      shift_amt = s1_count_q;
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s1_signed_d = s1_signed_q;
    s1_tag_d    = s1_tag_q;
    s1_count_d  = s1_count_q;
    s1_zero_d   = s1_zero_q;
    if (flush) begin
      s1_valid_d = 1'b0;
    end else if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d   = in_data;
        s1_signed_d = in_signed;
        s1_tag_d    = in_tag;
        s1_count_d  = count_sel;
        s1_zero_d   = (in_data == '0);
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_shift_d = out_shift_q;
    out_zero_d  = out_zero_q;
    out_tag_d   = out_tag_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (s1_advance) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d  = s1_zero_q ? '0 : (s1_data_q << shift_amt);
        out_shift_d = shift_amt;
        out_zero_d  = s1_zero_q;
        out_tag_d   = s1_tag_q;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_signed_q <= 1'b0;
      s1_tag_q    <= '0;
      s1_count_q  <= '0;
      s1_zero_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_shift_q <= '0;
      out_zero_q  <= 1'b0;
      out_tag_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_signed_q <= s1_signed_d;
      s1_tag_q    <= s1_tag_d;
      s1_count_q  <= s1_count_d;
      s1_zero_q   <= s1_zero_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_shift_q <= out_shift_d;
      out_zero_q  <= out_zero_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_shift = out_shift_q;
  assign out_zero  = out_zero_q;
  assign out_tag   = out_tag_q;

endmodule

`default_nettype wire

// File: tb/tb_normalization_shifter.sv
// ============================================================================
// tb_normalization_shifter: randomized and directed checks against a lossless-shift model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_normalization_shifter;

  localparam int DW = 64;
  localparam int SW = 6;
  localparam int TW = 4;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          in_signed = 1'b0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic [SW-1:0] out_shift;
  logic          out_zero;
  logic [TW-1:0] out_tag;

  normalization_shifter #(
    .DATA_WIDTH (DW),
    .SHIFT_WIDTH(SW),
    .TAG_WIDTH  (TW)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_signed(in_signed),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_shift(out_shift),
    .out_zero (out_zero),
    .out_tag  (out_tag)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [SW-1:0] sh;
    logic          z;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_out = 0;
  int   run = 0;
  int   max_run = 0;
  bit   saw_ready_low = 1'b0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Largest left shift that loses no information (value-preserving for signed),
  // capped so a signed result always keeps one sign bit below the top.
  function automatic exp_t model(input logic [DW-1:0] d, input logic s, input logic [TW-1:0] t);
    exp_t r;
    int best = 0;
    int cap = s ? DW - 2 : DW - 1;
    logic [DW-1:0] v;
    r.z = (d == '0);
    if (!r.z) begin
      for (int k = 0; k <= cap; k++) begin
        v = d << k;
        if (s ? (($signed(v) >>> k) == $signed(d)) : ((v >> k) == d)) best = k;
      end
    end
    r.sh  = SW'(best);
    r.d   = r.z ? '0 : (d << best);
    r.tag = t;
    return r;
  endfunction

  always @(negedge clock) begin
    if (reset_n) begin
      check("in_ready", {63'd0, in_ready}, {63'd0, !(q.size() == 2 && !out_ready)});
      if (!in_ready) saw_ready_low = 1'b1;
      if (out_valid) begin
        if (q.size() == 0) begin
          check("spurious_valid", 64'd1, 64'd0);
        end else begin
          e = q[0];
          check("out_data", out_data, e.d);
          check("out_shift", {58'd0, out_shift}, {58'd0, e.sh});
          check("out_zero", {63'd0, out_zero}, {63'd0, e.z});
          check("out_tag", {60'd0, out_tag}, {60'd0, e.tag});
          if (out_ready) begin
            void'(q.pop_front());
            n_out++;
          end
        end
      end
      if (out_valid && out_ready) run++;
      else run = 0;
      if (run > max_run) max_run = run;
      if (flush) q.delete();
      else if (in_valid && in_ready) q.push_back(model(in_data, in_signed, in_tag));
    end
  end

  // Called at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic send(input logic [DW-1:0] d, input logic s, input logic [TW-1:0] t);
    bit acc = 1'b0;
    int n = 0;
    in_data = d; in_signed = s; in_tag = t; in_valid = 1'b1;
    while (!acc && n < 50) begin
      @(negedge clock);
      acc = in_ready;
      @(posedge clock); #1;
      n++;
    end
    if (!acc) check("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (q.size() != 0 && n < 40) begin
      @(posedge clock); #1;
      n++;
    end
    check("drain_empty", 64'(q.size()), 64'd0);
  endtask

  function automatic logic [DW-1:0] rand_op();
    logic [DW-1:0] d;
    d = {$urandom, $urandom} >> ($urandom % DW);
    if ($urandom % 3 == 0) d = ~d;
    if ($urandom % 16 == 0) d = '0;
    if ($urandom % 16 == 0) d = '1;
    return d;
  endfunction

  logic [DW-1:0] vec_d[8] = '{64'h8000_0000_0000_0000, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF,
                              64'h0000_0000_0000_00FF, 64'hFFFF_FFFF_FFFF_FF00,
                              64'h4000_0000_0000_0000, 64'h8000_0000_0000_0000};
  logic          vec_s[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  bit            rand_run = 1'b0;
  int            out_before;

  initial begin
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_out_shift", {58'd0, out_shift}, 64'd0);
    check("rst_out_zero", {63'd0, out_zero}, 64'd0);
    check("rst_out_tag", {60'd0, out_tag}, 64'd0);
    @(posedge clock); #1;

    // Latency on 0x1: model gives shift 63, data 0x8000...
    send(64'h1, 1'b0, 4'hA);
    @(negedge clock);
    check("lat_cycle1", {63'd0, out_valid}, 64'd0);
    @(posedge clock); #1;
    @(negedge clock);
    check("lat_cycle2", {63'd0, out_valid}, 64'd1);
    check("lat_shift63", {58'd0, out_shift}, 64'd63);
    @(posedge clock); #1;
    drain();

    for (int i = 0; i < 8; i++) send(vec_d[i], vec_s[i], TW'(i));
    drain();

    // Back-to-back stream with no stall.
    saw_ready_low = 1'b0; max_run = 0; out_before = n_out;
    for (int i = 0; i < 8; i++) send(rand_op(), 1'($urandom), TW'(i));
    drain();
    check("stream_count", 64'(n_out - out_before), 64'd8);
    check("stream_run", 64'(max_run >= 8), 64'd1);
    check("stream_ready_hi", {63'd0, saw_ready_low}, 64'd0);

    // Same stream with a 3-cycle downstream stall.
    saw_ready_low = 1'b0; out_before = n_out;
    fork
      for (int i = 0; i < 8; i++) send(rand_op(), 1'($urandom), TW'(i));
      begin
        repeat (4) @(posedge clock);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("stall_count", 64'(n_out - out_before), 64'd8);
    check("stall_ready_fell", {63'd0, saw_ready_low}, 64'd1);

    // Flush with both stages full; the input offered in the flush cycle is dropped.
    out_ready = 1'b0;
    send(64'h0000_0000_0000_0F00, 1'b0, 4'h1);
    send(64'h0000_0000_00F0_0000, 1'b1, 4'h2);
    out_ready = 1'b1;
    flush = 1'b1;
    in_valid = 1'b1; in_data = 64'h1234; in_signed = 1'b0; in_tag = 4'h3;
    @(posedge clock); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clock);
    check("flush_out_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clock); #1;
    send(64'h0000_0000_0000_0003, 1'b0, 4'h4);
    drain();

    // Asynchronous reset mid-stream.
    out_ready = 1'b0;
    send(64'h0000_00FF_0000_0000, 1'b0, 4'h5);
    send(64'hFFFF_F000_0000_0000, 1'b1, 4'h6);
    #3 reset_n = 1'b0;
    #1;
    check("rst_async_valid", {63'd0, out_valid}, 64'd0);
    q.delete();
    @(posedge clock); #1 reset_n = 1'b1;
    out_ready = 1'b1;
    send(64'h0000_0000_0000_0070, 1'b1, 4'h7);
    drain();

    // Randomized traffic with random backpressure.
    rand_run = 1'b1;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send(rand_op(), 1'($urandom), TW'($urandom));
          if ($urandom % 4 == 0) begin
            @(posedge clock); #1;
          end
        end
        rand_run = 1'b0;
      end
      while (rand_run) begin
        @(posedge clock); #1;
        if (rand_run) out_ready = ($urandom % 4 != 0);
      end
    join
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/normalization_shifter.md
Name: normalization_shifter

Overview:
- Two-stage pipelined normalizer that sits directly downstream of the leading-bit counter.
- Stage 1 instantiates leading_bits_counter, with BIT_TO_COUNT chosen per transaction, to size the shift.
- Stage 2 barrel-shifts the operand left so its most-significant bit is significant, and reports the shift amount.
- Feeds the FP int-to-float converter and the divider pre-normalization, using a valid/ready handshake on both sides.

Parameters:
- DATA_WIDTH, 64, operand width; power of two, at least 4.
- SHIFT_WIDTH, $clog2(DATA_WIDTH), width of the shift amount.
- TAG_WIDTH, 4, width of the opaque transaction tag carried alongside the data.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous; drops all in-flight transactions.
- in_valid  input  1  upstream presents an operand.
- in_ready  output  1  block accepts the operand this cycle.
- in_data  input  DATA_WIDTH  operand.
- in_signed  input  1  1 = two's-complement normalization, 0 = unsigned.
- in_tag  input  TAG_WIDTH  passthrough tag.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  DATA_WIDTH  normalized operand.
- out_shift  output  SHIFT_WIDTH  left-shift amount applied.
- out_zero  output  1  operand was zero.
- out_tag  output  TAG_WIDTH  tag of the result.

Behaviour:
- Clock and reset: one clock. reset_n is asynchronous and active-low.
- Reset values: out_valid=0, out_data=0, out_shift=0, out_zero=0, out_tag=0. Stage-1 valid=0. in_ready=1 from the first cycle after reset deasserts.
- Handshake:
  - Transfer occurs on a cycle with valid&&ready.
  - in_ready = !s1_valid || s1_advance, where s1_advance = !out_valid || out_ready. No combinational path from in_valid to in_ready.
  - While out_valid && !out_ready, out_data, out_shift, out_zero and out_tag hold stable.
- Latency and throughput: 2 cycles from input transfer to out_valid with no stall. Sustains one result per cycle.
- Stage 1:
  - Registers in_data, in_signed and in_tag.
  - Registers count c from leading_bits_counter:
    - BIT_TO_COUNT=0 when unsigned, or when signed with in_data[MSB]=0.
    - BIT_TO_COUNT=1 when signed with in_data[MSB]=1.
    - Implement as two counter instances plus a mux.
  - Registers zero = (in_data==0).
  - The counter returns DATA_WIDTH-1 for all-zero and all-ones inputs.
- Stage 2 shift amount:
  - Unsigned: shift = c.
  - Signed: shift = c-1, saturating at 0.
- Stage 2 outputs: out_data = operand << shift, zero fill. out_zero = zero.
- Zero operand, both modes: out_zero=1, out_shift=0, out_data=0. Overrides the counter value.
- Signed all-ones (-1): c=DATA_WIDTH-1, shift=DATA_WIDTH-2, out_data = 0b110...0, out_zero=0.
- Already normalized (unsigned MSB=1, or signed with bit[MSB]!=bit[MSB-1]): shift=0, out_data = in_data.
- Flush:
  - Clears s1_valid and out_valid on the next edge, and takes priority over any transfer that cycle.
  - An input accepted in the flush cycle is discarded.
  - in_ready is unaffected.
- Reset mid-operation: all valids clear immediately (asynchronous). No partial result is emitted after release.
- Widths: all shift arithmetic is done in SHIFT_WIDTH bits. The signed c-1 never underflows, because c>=1 whenever the operand is non-zero in signed mode.

Test Plan:
- Unsigned 0x0000_0000_0000_0001 -> 2 cycles later out_data=0x8000_0000_0000_0000, out_shift=63, out_zero=0. Also 0x8000_0000_0000_0000 -> shift 0, data unchanged.
- Zero operand, unsigned and signed -> out_zero=1, out_shift=0, out_data=0. Signed 0xFFFF_FFFF_FFFF_FFFF -> out_data=0xC000_0000_0000_0000, out_shift=62.
- Signed 0x0000_0000_0000_00FF -> shift 55, out_data=0x7F80_0000_0000_0000. Signed 0xFFFF_FFFF_FFFF_FF00 -> shift 55, out_data=0x8000_0000_0000_0000.
- Back-to-back stream of 8 operands with tags 0..7 and out_ready=1 -> 8 consecutive out_valid cycles, tags in order, in_ready never drops.
- Same stream with out_ready held low for 3 cycles mid-stream:
  - Outputs are held stable throughout the stall.
  - in_ready falls once both stages are full.
  - No loss or duplication; tags arrive in order.
- Flush with both stages full, and reset_n pulsed low mid-stream -> out_valid=0 next cycle (immediately for reset). The first result out afterwards belongs to the first operand accepted after the flush/reset.
